// File: rtl/ga_main_ctr_if.sv
// Control/status bundle between the GA sequencer and its requester/datapath.
// The slave side is the sequencer; the master side drives run requests and stage done strobes.
interface ga_main_ctr_if #(
   parameter int GEN_W = 8
);
   logic             start;
   logic             abort;
   logic [GEN_W-1:0] num_gen;
   logic             fit_hit;
   logic             rd_done;
   logic             init_done;
   logic             eval_done;
   logic             sel_done;
   logic             xo_done;
   logic             mut_done;
   logic             out_ready;
   logic [3:0]       current_state;
   logic [5:0]       stage_start;
   logic [GEN_W-1:0] gen_cnt;
   logic             busy;
   logic             out_valid;
   logic             done;
   logic             err;
   logic [3:0]       err_stage;

   modport master (
      output start, abort, num_gen, fit_hit,
      output rd_done, init_done, eval_done, sel_done, xo_done, mut_done, out_ready,
      input  current_state, stage_start, gen_cnt, busy, out_valid, done, err, err_stage
   );

   modport slave (
      input  start, abort, num_gen, fit_hit,
      input  rd_done, init_done, eval_done, sel_done, xo_done, mut_done, out_ready,
      output current_state, stage_start, gen_cnt, busy, out_valid, done, err, err_stage
   );
endinterface

// File: rtl/ga_main_ctr.sv
// Generation-loop sequencer: read, init, then eval/select/xover/mutate until budget or fitness hit,
// with one-cycle stage start pulses, per-stage watchdog and a valid/ready result handoff.
module ga_main_ctr #(
   parameter int              GEN_W   = 8,
   parameter int              TO_W    = 16,
   parameter logic [TO_W-1:0] TIMEOUT = 16'd50000
) (
   input logic          clk,
   input logic          rst,
   ga_main_ctr_if.slave bus
);
   localparam logic [3:0] ST_IDLE = 4'd0;
   localparam logic [3:0] ST_RD   = 4'd1;
   localparam logic [3:0] ST_INIT = 4'd2;
   localparam logic [3:0] ST_EVAL = 4'd3;
   localparam logic [3:0] ST_SEL  = 4'd4;
   localparam logic [3:0] ST_XO   = 4'd5;
   localparam logic [3:0] ST_MUT  = 4'd6;
   localparam logic [3:0] ST_OUT  = 4'd7;
   localparam logic [3:0] ST_ERR  = 4'd8;

   // Watchdog fires in the TIMEOUT-th cycle of a stage, so a stage may live TIMEOUT cycles.
   localparam logic [TO_W-1:0] WD_LAST = TIMEOUT - 1'b1;
   localparam bit              WD_EN   = (TIMEOUT != '0);

   logic [3:0]       state_reg, state_next;
   logic [5:0]       stage_start_reg, stage_start_next;
   logic [GEN_W-1:0] gen_cnt_reg, gen_cnt_next;
   logic [GEN_W-1:0] num_gen_q_reg, num_gen_q_next;
   logic [TO_W-1:0]  wd_reg, wd_next;
   logic             busy_reg, out_valid_reg, done_reg, err_reg;
   logic [3:0]       err_stage_reg;
   logic             in_stage, stage_done, done_ok, wd_fire, state_chg;
   logic [3:0]       stage_tgt;

   always_comb begin
      stage_done = 1'b0;
      stage_tgt  = ST_IDLE;
      in_stage   = 1'b1;
      case (state_reg)
         ST_RD:   begin stage_done = bus.rd_done;   stage_tgt = ST_INIT; end
         ST_INIT: begin stage_done = bus.init_done; stage_tgt = ST_EVAL; end
         ST_EVAL: begin
            stage_done = bus.eval_done;
            stage_tgt  = (bus.fit_hit || (gen_cnt_reg == num_gen_q_reg)) ? ST_OUT : ST_SEL;
         end
         ST_SEL:  begin stage_done = bus.sel_done;  stage_tgt = ST_XO;   end
         ST_XO:   begin stage_done = bus.xo_done;   stage_tgt = ST_MUT;  end
         ST_MUT:  begin stage_done = bus.mut_done;  stage_tgt = ST_EVAL; end
         default: in_stage = 1'b0;
      endcase
   end

   // A strobe coinciding with the start pulse belongs to a previous operation and is dropped.
   assign done_ok = stage_done && (stage_start_reg == '0);
   assign wd_fire = WD_EN && (wd_reg == WD_LAST);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (bus.start) state_next = ST_RD;
         ST_OUT:  if (out_valid_reg && bus.out_ready) state_next = ST_IDLE;
         ST_ERR:  state_next = ST_ERR;
         default: begin
            if (in_stage) begin
               if (done_ok)      state_next = stage_tgt;
               else if (wd_fire) state_next = ST_ERR;
            end else begin
               state_next = ST_IDLE;
            end
         end
      endcase
      if (bus.abort) state_next = ST_IDLE;
   end

   assign state_chg = (state_next != state_reg);

   always_comb begin
      gen_cnt_next = gen_cnt_reg;
      if (state_chg && (state_next == ST_INIT))
         gen_cnt_next = '0;
      else if ((state_reg == ST_MUT) && (state_next == ST_EVAL) && (gen_cnt_reg != '1))
         gen_cnt_next = gen_cnt_reg + 1'b1;

      num_gen_q_next = ((state_reg == ST_IDLE) && (state_next == ST_RD)) ? bus.num_gen : num_gen_q_reg;

      wd_next = wd_reg;
      if (state_chg)
         wd_next = '0;
      else if (in_stage && (wd_reg != '1))
         wd_next = wd_reg + 1'b1;
   end

   for (genvar gi = 0; gi < 6; gi++) begin : g_pulse
      assign stage_start_next[gi] = state_chg && (state_next == 4'(gi + 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= ST_IDLE;
         stage_start_reg <= '0;
         gen_cnt_reg     <= '0;
         num_gen_q_reg   <= '0;
         wd_reg          <= '0;
         busy_reg        <= 1'b0;
         out_valid_reg   <= 1'b0;
         done_reg        <= 1'b0;
         err_reg         <= 1'b0;
         err_stage_reg   <= '0;
      end else begin
         state_reg       <= state_next;
         stage_start_reg <= stage_start_next;
         gen_cnt_reg     <= gen_cnt_next;
         num_gen_q_reg   <= num_gen_q_next;
         wd_reg          <= wd_next;
         busy_reg        <= (state_next != ST_IDLE) && (state_next != ST_ERR);
         out_valid_reg   <= (state_next == ST_OUT);
         done_reg        <= (state_reg == ST_OUT) && (state_next == ST_IDLE) && !bus.abort;
         err_reg         <= (state_next == ST_ERR);
         if (state_chg)
            err_stage_reg <= (state_next == ST_ERR) ? state_reg : 4'd0;
      end
   end

   assign bus.current_state = state_reg;
   assign bus.stage_start   = stage_start_reg;
   assign bus.gen_cnt       = gen_cnt_reg;
   assign bus.busy          = busy_reg;
   assign bus.out_valid     = out_valid_reg;
   assign bus.done          = done_reg;
   assign bus.err           = err_reg;
   assign bus.err_stage     = err_stage_reg;
endmodule

// File: tb/tb_ga_main_ctr.sv
// Directed bench for ga_main_ctr: a per-cycle vector table for a 2-generation run,
// then hand-written sequences for fitness exit, watchdog, output stall, abort and async reset.
module tb_ga_main_ctr;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ga_main_ctr_if #(.GEN_W(8)) bus ();

   ga_main_ctr #(.GEN_W(8), .TO_W(16), .TIMEOUT(16'd8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic       start;
      logic [5:0] dn;
      logic [3:0] e_state;
      logic [5:0] e_ss;
      logic [7:0] e_gen;
      logic       e_busy;
      logic       e_ov;
      logic       e_done;
   } vec_t;

   vec_t vecs[26];
   int   n_total = 0;
   int   n_bad   = 0;
   int   pulse_cnt[6];
   int   sel0, ev0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {6'd0, bus.current_state, bus.stage_start, bus.gen_cnt,
              bus.busy, bus.out_valid, bus.done, bus.err, bus.err_stage};
   endfunction

   function automatic vec_t mk(input logic st, input logic [5:0] dn, input logic [3:0] es,
                               input logic [5:0] ess, input logic [7:0] eg,
                               input logic eb, input logic eov, input logic ed);
      vec_t v;
      v.start = st; v.dn = dn; v.e_state = es; v.e_ss = ess;
      v.e_gen = eg; v.e_busy = eb; v.e_ov = eov; v.e_done = ed;
      return v;
   endfunction

   task automatic tick();
      @(negedge clk);
      for (int k = 0; k < 6; k++) pulse_cnt[k] += int'(bus.stage_start[k]);
   endtask

   task automatic set_dn(input logic [5:0] d);
      bus.rd_done   = d[0];
      bus.init_done = d[1];
      bus.eval_done = d[2];
      bus.sel_done  = d[3];
      bus.xo_done   = d[4];
      bus.mut_done  = d[5];
   endtask

   // Called in a stage's pulse cycle: wait one cycle, then strobe its done for one cycle.
   task automatic finish_stage(input int k, input logic fh);
      set_dn(6'd0);
      tick();
      set_dn(6'(1 << k));
      bus.fit_hit = fh;
      tick();
      set_dn(6'd0);
      bus.fit_hit = 1'b0;
   endtask

   task automatic start_run(input logic [7:0] ng);
      bus.num_gen = ng;
      bus.start   = 1'b1;
      tick();
      bus.start   = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 6; k++) pulse_cnt[k] = 0;
      rst = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.num_gen = 8'd0; bus.fit_hit = 1'b0;
      bus.out_ready = 1'b1;
      set_dn(6'd0);

      //            start dn      state ss     gen  busy ov done
      vecs[0]  = mk(1'b1, 6'h00, 4'd1, 6'h01, 8'd0, 1'b1, 1'b0, 1'b0);
      vecs[1]  = mk(1'b0, 6'h01, 4'd1, 6'h00, 8'd0, 1'b1, 1'b0, 1'b0);
      vecs[2]  = mk(1'b0, 6'h01, 4'd2, 6'h02, 8'd0, 1'b1, 1'b0, 1'b0);
      vecs[3]  = mk(1'b0, 6'h3D, 4'd2, 6'h00, 8'd0, 1'b1, 1'b0, 1'b0);
      vecs[4]  = mk(1'b0, 6'h02, 4'd3, 6'h04, 8'd0, 1'b1, 1'b0, 1'b0);
      vecs[5]  = mk(1'b0, 6'h00, 4'd3, 6'h00, 8'd0, 1'b1, 1'b0, 1'b0);
      vecs[6]  = mk(1'b0, 6'h3B, 4'd3, 6'h00, 8'd0, 1'b1, 1'b0, 1'b0);
      vecs[7]  = mk(1'b0, 6'h04, 4'd4, 6'h08, 8'd0, 1'b1, 1'b0, 1'b0);
      vecs[8]  = mk(1'b0, 6'h00, 4'd4, 6'h00, 8'd0, 1'b1, 1'b0, 1'b0);
      vecs[9]  = mk(1'b0, 6'h08, 4'd5, 6'h10, 8'd0, 1'b1, 1'b0, 1'b0);
      vecs[10] = mk(1'b0, 6'h00, 4'd5, 6'h00, 8'd0, 1'b1, 1'b0, 1'b0);
      vecs[11] = mk(1'b0, 6'h10, 4'd6, 6'h20, 8'd0, 1'b1, 1'b0, 1'b0);
      vecs[12] = mk(1'b0, 6'h00, 4'd6, 6'h00, 8'd0, 1'b1, 1'b0, 1'b0);
      vecs[13] = mk(1'b0, 6'h20, 4'd3, 6'h04, 8'd1, 1'b1, 1'b0, 1'b0);
      vecs[14] = mk(1'b0, 6'h00, 4'd3, 6'h00, 8'd1, 1'b1, 1'b0, 1'b0);
      vecs[15] = mk(1'b0, 6'h04, 4'd4, 6'h08, 8'd1, 1'b1, 1'b0, 1'b0);
      vecs[16] = mk(1'b0, 6'h00, 4'd4, 6'h00, 8'd1, 1'b1, 1'b0, 1'b0);
      vecs[17] = mk(1'b0, 6'h08, 4'd5, 6'h10, 8'd1, 1'b1, 1'b0, 1'b0);
      vecs[18] = mk(1'b0, 6'h00, 4'd5, 6'h00, 8'd1, 1'b1, 1'b0, 1'b0);
      vecs[19] = mk(1'b0, 6'h10, 4'd6, 6'h20, 8'd1, 1'b1, 1'b0, 1'b0);
      vecs[20] = mk(1'b0, 6'h00, 4'd6, 6'h00, 8'd1, 1'b1, 1'b0, 1'b0);
      vecs[21] = mk(1'b0, 6'h20, 4'd3, 6'h04, 8'd2, 1'b1, 1'b0, 1'b0);
      vecs[22] = mk(1'b0, 6'h00, 4'd3, 6'h00, 8'd2, 1'b1, 1'b0, 1'b0);
      vecs[23] = mk(1'b0, 6'h04, 4'd7, 6'h00, 8'd2, 1'b1, 1'b1, 1'b0);
      vecs[24] = mk(1'b0, 6'h00, 4'd0, 6'h00, 8'd2, 1'b0, 1'b0, 1'b1);
      vecs[25] = mk(1'b0, 6'h00, 4'd0, 6'h00, 8'd2, 1'b0, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      check("reset_outputs", outs(), 32'd0);
      rst = 1'b1;
      tick();
      check("idle_after_reset", outs(), 32'd0);

      // Two-generation run, including a done in its pulse cycle and foreign strobes.
      bus.num_gen = 8'd2;
      for (int i = 0; i < 26; i++) begin
         bus.start = vecs[i].start;
         set_dn(vecs[i].dn);
         tick();
         $display("vec %0d state=%0d ss=%02h gen=%0d busy=%0d ov=%0d done=%0d", i,
                  bus.current_state, bus.stage_start, bus.gen_cnt, bus.busy, bus.out_valid, bus.done);
         check($sformatf("vec%0d", i),
               {12'd0, bus.current_state, bus.stage_start, bus.gen_cnt, bus.busy, bus.out_valid, bus.done},
               {12'd0, vecs[i].e_state, vecs[i].e_ss, vecs[i].e_gen, vecs[i].e_busy, vecs[i].e_ov, vecs[i].e_done});
      end
      bus.start = 1'b0;
      set_dn(6'd0);
      check("pulses_eval", pulse_cnt[2], 3);
      check("pulses_sel", pulse_cnt[3], 2);
      check("pulses_mut", pulse_cnt[5], 2);

      // Fitness target on the second eval ends the run early.
      sel0 = pulse_cnt[3];
      start_run(8'd5);
      finish_stage(0, 1'b0); finish_stage(1, 1'b0); finish_stage(2, 1'b0);
      finish_stage(3, 1'b0); finish_stage(4, 1'b0); finish_stage(5, 1'b0);
      finish_stage(2, 1'b1);
      $display("fit: state=%0d gen=%0d ov=%0d", bus.current_state, bus.gen_cnt, bus.out_valid);
      check("fit_state", bus.current_state, 4'd7);
      check("fit_gen", bus.gen_cnt, 8'd1);
      check("fit_ov", bus.out_valid, 1'b1);
      check("fit_sel_once", pulse_cnt[3], sel0 + 1);
      tick();
      check("fit_done", {bus.current_state, bus.done}, {4'd0, 1'b1});

      // Watchdog: xo_done withheld, ERROR after 8 cycles in XOVER.
      start_run(8'd3);
      finish_stage(0, 1'b0); finish_stage(1, 1'b0); finish_stage(2, 1'b0); finish_stage(3, 1'b0);
      repeat (7) tick();
      check("wd_still_xover", bus.current_state, 4'd5);
      tick();
      $display("wd: state=%0d err=%0d err_stage=%0d", bus.current_state, bus.err, bus.err_stage);
      check("wd_error", {bus.current_state, bus.err, bus.err_stage, bus.busy}, {4'd8, 1'b1, 4'd5, 1'b0});
      bus.start = 1'b1;
      repeat (3) tick();
      bus.start = 1'b0;
      check("err_hold_start", {bus.current_state, bus.err, bus.err_stage}, {4'd8, 1'b1, 4'd5});
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("err_abort", {bus.current_state, bus.err, bus.err_stage, bus.done}, {4'd0, 1'b0, 4'd0, 1'b0});

      // num_gen=0 with stalled output.
      bus.out_ready = 1'b0;
      ev0  = pulse_cnt[2];
      sel0 = pulse_cnt[3];
      start_run(8'd0);
      finish_stage(0, 1'b0); finish_stage(1, 1'b0); finish_stage(2, 1'b0);
      check("ng0_state", {bus.current_state, bus.gen_cnt, bus.out_valid}, {4'd7, 8'd0, 1'b1});
      check("ng0_one_eval", pulse_cnt[2], ev0 + 1);
      check("ng0_no_sel", pulse_cnt[3], sel0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("stall%0d", i), {bus.current_state, bus.out_valid, bus.done}, {4'd7, 1'b1, 1'b0});
      end
      bus.out_ready = 1'b1;
      tick();
      $display("stall release: state=%0d ov=%0d done=%0d", bus.current_state, bus.out_valid, bus.done);
      check("stall_release", {bus.current_state, bus.out_valid, bus.done}, {4'd7 - 4'd7, 1'b0, 1'b1});
      tick();
      check("done_one_cycle", bus.done, 1'b0);

      // Abort in EVAL keeps gen_cnt.
      start_run(8'd3);
      finish_stage(0, 1'b0); finish_stage(1, 1'b0); finish_stage(2, 1'b0);
      finish_stage(3, 1'b0); finish_stage(4, 1'b0); finish_stage(5, 1'b0);
      tick();
      check("in_eval_gen1", {bus.current_state, bus.gen_cnt}, {4'd3, 8'd1});
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abort_eval", outs(), {6'd0, 4'd0, 6'd0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
      tick();
      check("abort_no_done", bus.done, 1'b0);

      // Async reset mid-MUTATE.
      start_run(8'd3);
      finish_stage(0, 1'b0); finish_stage(1, 1'b0); finish_stage(2, 1'b0);
      finish_stage(3, 1'b0); finish_stage(4, 1'b0); finish_stage(5, 1'b0);
      finish_stage(2, 1'b0); finish_stage(3, 1'b0); finish_stage(4, 1'b0);
      check("in_mutate", {bus.current_state, bus.stage_start, bus.gen_cnt}, {4'd6, 6'h20, 8'd1});
      #2 rst = 1'b0;
      #1 check("async_rst", outs(), 32'd0);
      $display("async rst: state=%0d gen=%0d", bus.current_state, bus.gen_cnt);
      #1 rst = 1'b1;
      tick();
      check("after_rst", outs(), 32'd0);
      tick();
      check("after_rst_no_done", bus.done, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
